// File: rtl/spi_master_multi_if.sv
// Bus bundle between the system controller and spi_master_multi.
// The master modport is the SPI master's view; slave is the controller/bench view.
interface spi_master_multi_if #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 1,
    parameter int DIV_W  = 8
);
    localparam int N_SS = 1 << SEL_W;

    logic              CKP;
    logic              CPH;
    logic              strt;
    logic [SEL_W-1:0]  ss_sel;
    logic [DIV_W-1:0]  div;
    logic [DATA_W-1:0] data_in;
    logic              MISO;
    logic              MOSI;
    logic              SCK;
    logic [N_SS-1:0]   CS;
    logic [DATA_W-1:0] data_out;
    logic              busy;
    logic              done;

    modport master (
        input  CKP, CPH, strt, ss_sel, div, data_in, MISO,
        output MOSI, SCK, CS, data_out, busy, done
    );

    modport slave (
        output CKP, CPH, strt, ss_sel, div, data_in, MISO,
        input  MOSI, SCK, CS, data_out, busy, done
    );
endinterface

// File: rtl/spi_master_multi.sv
// Parametrised full-duplex SPI master with N_SS active-low chip selects,
// programmable SCK half-period and all four CKP/CPH modes. Every output is a
// flop; the whole sequencer lives in one clocked process.
module spi_master_multi #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 1,
    parameter int DIV_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    spi_master_multi_if.master bus
);
    localparam int N_SS   = 1 << SEL_W;
    localparam int EDGE_W = $clog2(2 * DATA_W) + 1;
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    // LOAD is the single cycle between strt acceptance and CS assertion.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SETUP = 3'd2,
        XFER  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t            state_r;
    logic [DATA_W-1:0] tx_r;
    logic [DATA_W-1:0] rx_r;
    logic [SEL_W-1:0]  sel_r;
    logic              ckp_r;
    logic              cph_r;
    logic [DIV_W-1:0]  div_r;
    logic [DIV_W-1:0]  cnt_r;
    logic [EDGE_W-1:0] edge_r;
    logic              sck_r;
    logic              mosi_r;
    logic [N_SS-1:0]   cs_r;
    logic [DATA_W-1:0] data_out_r;
    logic              busy_r;
    logic              done_r;

    logic              expire_s;
    logic              leading_s;
    logic              last_edge_s;
    logic [DATA_W-1:0] rx_next_s;

    // One-hot-low chip-select pattern for a slave index; every index is legal.
    function automatic logic [N_SS-1:0] cs_decode(input logic [SEL_W-1:0] sel);
        logic [N_SS-1:0] pat;
        pat      = {N_SS{1'b1}};
        pat[sel] = 1'b0;
        return pat;
    endfunction

    // Half-period counter runs down from div to zero, so div all-ones never wraps.
    assign expire_s    = (cnt_r == {DIV_W{1'b0}});
    // Edge index is zero-based: even index means an odd (leading) SCK edge.
    assign leading_s   = ~edge_r[0];
    assign last_edge_s = (edge_r == LAST_EDGE);
    assign rx_next_s   = {rx_r[DATA_W-2:0], bus.MISO};

    assign bus.SCK      = sck_r;
    assign bus.MOSI     = mosi_r;
    assign bus.CS       = cs_r;
    assign bus.data_out = data_out_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;

    // Transfer sequencer: accept, assert CS, setup, 2*DATA_W SCK edges, hold, release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            tx_r       <= {DATA_W{1'b0}};
            rx_r       <= {DATA_W{1'b0}};
            sel_r      <= {SEL_W{1'b0}};
            ckp_r      <= 1'b0;
            cph_r      <= 1'b0;
            div_r      <= {DIV_W{1'b0}};
            cnt_r      <= {DIV_W{1'b0}};
            edge_r     <= {EDGE_W{1'b0}};
            sck_r      <= 1'b0;
            mosi_r     <= 1'b0;
            cs_r       <= {N_SS{1'b1}};
            data_out_r <= {DATA_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    sck_r  <= bus.CKP;
                    cs_r   <= {N_SS{1'b1}};
                    busy_r <= 1'b0;
                    if (bus.strt) begin
                        tx_r    <= bus.data_in;
                        sel_r   <= bus.ss_sel;
                        ckp_r   <= bus.CKP;
                        cph_r   <= bus.CPH;
                        div_r   <= bus.div;
                        state_r <= LOAD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    cs_r    <= cs_decode(sel_r);
                    busy_r  <= 1'b1;
                    sck_r   <= ckp_r;
                    mosi_r  <= tx_r[DATA_W-1];
                    rx_r    <= {DATA_W{1'b0}};
                    cnt_r   <= div_r;
                    edge_r  <= {EDGE_W{1'b0}};
                    state_r <= SETUP;
                end
                SETUP: begin
                    if (expire_s) begin
                        cnt_r   <= div_r;
                        state_r <= XFER;
                    end else begin
                        cnt_r <= cnt_r - DIV_W'(1'b1);
                    end
                end
                XFER: begin
                    if (expire_s) begin
                        sck_r  <= ~sck_r;
                        cnt_r  <= div_r;
                        edge_r <= edge_r + EDGE_W'(1'b1);
                        if (leading_s) begin
                            if (cph_r) begin
                                // Mode CPH=1 presents each bit on the leading edge.
                                mosi_r <= tx_r[DATA_W-1];
                                tx_r   <= tx_r << 1;
                            end else begin
                                rx_r <= rx_next_s;
                            end
                        end else begin
                            if (cph_r) begin
                                rx_r <= rx_next_s;
                            end else if (!last_edge_s) begin
                                // MSB is already on MOSI from LOAD; shift in the next bit.
                                mosi_r <= tx_r[DATA_W-2];
                                tx_r   <= tx_r << 1;
                            end else begin
                                mosi_r <= mosi_r;
                            end
                        end
                        if (last_edge_s) begin
                            state_r <= HOLD;
                        end else begin
                            state_r <= XFER;
                        end
                    end else begin
                        cnt_r <= cnt_r - DIV_W'(1'b1);
                    end
                end
                HOLD: begin
                    sck_r <= ckp_r;
                    if (expire_s) begin
                        cs_r       <= {N_SS{1'b1}};
                        data_out_r <= rx_r;
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - DIV_W'(1'b1);
                    end
                end
                default: begin
                    cs_r    <= {N_SS{1'b1}};
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_multi.sv
// Directed scoreboard bench for spi_master_multi: a 16-bit/1-bit-select instance
// with a behavioural slave, and an 8-bit/2-bit-select instance in loopback.
module tb_spi_master_multi;
    typedef struct {
        logic [15:0] data;
        logic [15:0] slave;
        int          edges;
        int          gap;
        int          cs_low;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    item_t sb_a[$];
    item_t sb_b[$];

    always #5 clk = ~clk;

    spi_master_multi_if #(.DATA_W(16), .SEL_W(1), .DIV_W(8)) ifa ();
    spi_master_multi_if #(.DATA_W(8),  .SEL_W(2), .DIV_W(8)) ifb ();

    spi_master_multi #(.DATA_W(16), .SEL_W(1), .DIV_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.master)
    );

    spi_master_multi #(.DATA_W(8), .SEL_W(2), .DIV_W(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.master)
    );

    // Slave model on CS[0] of instance A
    logic        mode_ckp = 1'b0;
    logic        mode_cph = 1'b0;
    logic        loop_a   = 1'b0;
    logic [15:0] slave_word = 16'h0000;
    logic [15:0] s_tx = 16'h0000;
    logic [15:0] s_rx = 16'h0000;
    logic        s_miso = 1'b0;
    int          s_edges = 0;
    int          cs_low_a = 0;
    int          gap_cnt = 0;
    int          gap_min = 0;
    int          gap_max = 0;
    logic        gap_seen = 1'b0;
    logic        sck_prev_a = 1'b0;
    int          edges_b = 0;
    logic        b_idle;

    assign ifa.MISO = loop_a ? ifa.MOSI : s_miso;
    assign ifb.MISO = ifb.MOSI;
    assign b_idle   = &ifb.CS;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge ifa.CS[0]) begin
        s_tx     = slave_word;
        s_rx     = 16'h0000;
        s_miso   = s_tx[15];
        s_edges  = 0;
        cs_low_a = 0;
    end

    always @(ifa.SCK) begin
        if (ifa.CS[0] == 1'b0) begin
            s_edges++;
            if ((ifa.SCK != mode_ckp) != mode_cph) begin
                s_rx = {s_rx[14:0], ifa.MOSI};
            end else if (mode_cph == 1'b0) begin
                s_tx   = s_tx << 1;
                s_miso = s_tx[15];
            end else begin
                s_miso = s_tx[15];
                s_tx   = s_tx << 1;
            end
        end
    end

    always @(ifb.SCK) begin
        if (b_idle == 1'b0) edges_b++;
    end

    always @(negedge b_idle) edges_b = 0;

    // SCK half-period and CS-low duration tracking for instance A
    always @(negedge clk) begin
        if (ifa.CS[0] == 1'b1) begin
            gap_seen = 1'b0;
        end else begin
            cs_low_a++;
            gap_cnt++;
            if (ifa.SCK != sck_prev_a) begin
                if (gap_seen) begin
                    if (gap_cnt < gap_min) gap_min = gap_cnt;
                    if (gap_cnt > gap_max) gap_max = gap_cnt;
                end else begin
                    gap_seen = 1'b1;
                    gap_min  = 1000;
                    gap_max  = 0;
                end
                gap_cnt = 0;
            end
        end
        sck_prev_a = ifa.SCK;
    end

    // Scoreboard monitor for instance A
    always @(negedge clk) begin
        item_t it;
        if (ifa.done === 1'b1) begin
            chk("a_done_expected", (sb_a.size() != 0), 1);
            if (sb_a.size() != 0) begin
                it = sb_a.pop_front();
                chk("a_data_out", ifa.data_out, it.data);
                chk("a_slave_rx", s_rx, it.slave);
                chk("a_sck_edges", s_edges, it.edges);
                chk("a_half_min", gap_min, it.gap);
                chk("a_half_max", gap_max, it.gap);
                chk("a_cs_low_cycles", cs_low_a, it.cs_low);
                chk("a_cs_release", ifa.CS, 2'b11);
                chk("a_busy_clear", ifa.busy, 1'b0);
            end
        end
    end

    // Scoreboard monitor for instance B
    always @(negedge clk) begin
        item_t it;
        if (ifb.done === 1'b1) begin
            chk("b_done_expected", (sb_b.size() != 0), 1);
            if (sb_b.size() != 0) begin
                it = sb_b.pop_front();
                chk("b_data_out", {8'h00, ifb.data_out}, it.data);
                chk("b_sck_edges", edges_b, it.edges);
                chk("b_cs_release", ifb.CS, 4'b1111);
            end
        end
    end

    task automatic issue_a(input logic ckp, input logic cph, input logic [7:0] dv,
                           input logic [15:0] din, input logic [15:0] swd,
                           input logic lp, input int gap);
        item_t it;
        @(negedge clk);
        mode_ckp    = ckp;
        mode_cph    = cph;
        loop_a      = lp;
        slave_word  = swd;
        ifa.CKP     = ckp;
        ifa.CPH     = cph;
        ifa.div     = dv;
        ifa.data_in = din;
        ifa.ss_sel  = 1'b0;
        ifa.strt    = 1'b1;
        it.data   = lp ? din : swd;
        it.slave  = din;
        it.edges  = 32;
        it.gap    = gap;
        it.cs_low = 34 * gap;
        sb_a.push_back(it);
        @(negedge clk);
        ifa.strt = 1'b0;
    endtask

    task automatic issue_b(input logic [7:0] din, input logic [1:0] sel);
        item_t it;
        ifb.data_in = din;
        ifb.ss_sel  = sel;
        ifb.strt    = 1'b1;
        it.data   = {8'h00, din};
        it.slave  = 16'h0000;
        it.edges  = 16;
        it.gap    = 1;
        it.cs_low = 0;
        sb_b.push_back(it);
        @(negedge clk);
        ifb.strt = 1'b0;
    endtask

    task automatic wait_done_a(output int lat);
        lat = 0;
        for (int i = 1; i <= 3000; i++) begin
            @(posedge clk);
            #1;
            if (ifa.done === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL a_timeout: got no done expected done within 3000 cycles");
        end
    endtask

    int t2_div[4] = '{0, 1, 2, 0};
    int t2_lat[4] = '{35, 69, 103, 35};

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int    lat;
        int    found;
        int    hi;
        item_t dropped;

        rst = 1'b1;
        ifa.CKP = 1'b0; ifa.CPH = 1'b0; ifa.strt = 1'b0; ifa.ss_sel = 1'b0;
        ifa.div = 8'd0; ifa.data_in = 16'h0000;
        ifb.CKP = 1'b0; ifb.CPH = 1'b0; ifb.strt = 1'b0; ifb.ss_sel = 2'd0;
        ifb.div = 8'd0; ifb.data_in = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_cs_a", ifa.CS, 2'b11);
        chk("rst_sck_a", ifa.SCK, 1'b0);
        chk("rst_mosi_a", ifa.MOSI, 1'b0);
        chk("rst_data_a", ifa.data_out, 16'h0000);
        chk("rst_busy_a", ifa.busy, 1'b0);
        chk("rst_done_a", ifa.done, 1'b0);
        chk("rst_cs_b", ifb.CS, 4'b1111);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: CKP=1 CPH=0, div=0, loopback
        issue_a(1'b1, 1'b0, 8'd0, 16'h5555, 16'h0000, 1'b1, 1);
        wait_done_a(lat);
        chk("t1_latency", lat, 35);

        // 2: all four modes against a slave returning 0F0F
        for (int m = 0; m < 4; m++) begin
            issue_a(m[1], m[0], 8'(t2_div[m]), 16'hA5C3, 16'h0F0F, 1'b0, t2_div[m] + 1);
            wait_done_a(lat);
            chk("t2_latency", lat, t2_lat[m]);
        end

        // 3: div=3 latency and half-period
        issue_a(1'b0, 1'b1, 8'd3, 16'h9A7E, 16'h6DB1, 1'b0, 4);
        wait_done_a(lat);
        chk("t3_latency", lat, 137);

        // 4: strt mid-transfer with new data/select is ignored
        issue_a(1'b0, 1'b0, 8'd1, 16'h1234, 16'h3C3C, 1'b0, 2);
        repeat (20) @(negedge clk);
        ifa.data_in = 16'hFFFF;
        ifa.ss_sel  = 1'b1;
        ifa.strt    = 1'b1;
        @(negedge clk);
        ifa.strt = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_cs_during", ifa.CS, 2'b10);
        chk("t4_busy_during", ifa.busy, 1'b1);
        wait_done_a(lat);
        repeat (20) @(negedge clk);
        chk("t4_busy_after", ifa.busy, 1'b0);
        chk("t4_cs_after", ifa.CS, 2'b11);
        chk("t4_data_hold", ifa.data_out, 16'h3C3C);

        // 5: reset at SCK edge 10, then a clean transfer
        issue_a(1'b1, 1'b0, 8'd0, 16'hBEEF, 16'h1357, 1'b0, 1);
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (s_edges == 10) break;
        end
        chk("t5_edge_reach", s_edges, 10);
        rst = 1'b1;
        #1;
        chk("t5_rst_cs", ifa.CS, 2'b11);
        chk("t5_rst_sck", ifa.SCK, 1'b0);
        chk("t5_rst_busy", ifa.busy, 1'b0);
        dropped = sb_a.pop_back();
        @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        chk("t5_data_cleared", ifa.data_out, 16'h0000);
        issue_a(1'b1, 1'b1, 8'd0, 16'hC0DE, 16'h4242, 1'b0, 1);
        wait_done_a(lat);
        chk("t5_latency", lat, 35);

        // 6: 8-bit instance, back-to-back to slaves 2 then 3
        @(negedge clk);
        issue_b(8'hA6, 2'd2);
        repeat (4) @(negedge clk);
        chk("t6_cs_first", ifb.CS, 4'b1011);
        found = 0;
        for (int i = 0; i < 500; i++) begin
            if (ifb.done === 1'b1) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("t6_done1_seen", found, 1);
        issue_b(8'h3C, 2'd3);
        hi = 1;
        while (ifb.CS == 4'b1111 && hi < 50) begin
            hi++;
            @(negedge clk);
        end
        chk("t6_cs_gap_ok", (hi >= 1 && hi <= 3), 1);
        chk("t6_cs_second", ifb.CS, 4'b0111);
        found = 0;
        for (int i = 0; i < 500; i++) begin
            if (ifb.done === 1'b1) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("t6_done2_seen", found, 1);

        repeat (10) @(negedge clk);
        chk("a_sb_drained", sb_a.size(), 0);
        chk("b_sb_drained", sb_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
